// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op and status codes match the hazard-control interface bit for bit.
package muldiv_pkg;

    localparam int XLEN_DEF  = 16;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DONE = 2'b01,
        ST_BUSY = 2'b10,
        ST_LAST = 2'b11
    } status_e;

    function automatic logic is_div_op(input op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // MULH and REM take their result from the upper accumulator half.
    function automatic logic takes_hi(input op_e op);
        return (op == OP_MULH) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide
// over the {acc_hi, acc_lo} accumulator pair.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  op_e             op,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] acc_hi_nxt,
    output logic [XLEN-1:0] acc_lo_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        rem_sh = {acc_hi, acc_lo[XLEN-1]};
        // Remainder stays below the divisor, so diff[XLEN] is exactly the borrow.
        diff   = rem_sh - {1'b0, operand};
        if (is_div_op(op)) begin
            if (!diff[XLEN]) begin
                acc_hi_nxt = diff[XLEN-1:0];
                acc_lo_nxt = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                acc_hi_nxt = rem_sh[XLEN-1:0];
                acc_lo_nxt = {acc_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_hi_nxt = sum[XLEN:1];
            acc_lo_nxt = {sum[0], acc_lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative unsigned MUL/MULH/DIV/REM for the EX stage; drives alu_status to hazard control.
// Optional MULDIV_EARLY_EXIT_EN shortens multiplies once the remaining multiplier bits are zero.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [3:0]      rd_in,
    input  logic            flush,
    output logic [1:0]      alu_status,
    output logic [XLEN-1:0] result,
    output logic [3:0]      rd_out,
    output logic            result_valid
);

    status_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e             op_q, op_d;
    logic [XLEN-1:0] acc_hi_q, acc_hi_d;
    logic [XLEN-1:0] acc_lo_q, acc_lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [3:0]      rd_q, rd_d;
    logic            dz_q, dz_d;
    logic [XLEN-1:0] step_hi, step_lo;
    op_e             op_in;
    logic            done_vis;
`ifdef MULDIV_EARLY_EXIT_EN
    logic            ee_q, ee_d;
    logic [XLEN-1:0] rem_bits;
    logic [CNT_W-1:0] sh_amt;
`endif

    assign op_in = op_e'(op);

    muldiv_step #(.XLEN(XLEN)) u_step (
        .op        (op_q),
        .acc_hi    (acc_hi_q),
        .acc_lo    (acc_lo_q),
        .operand   (opnd_q),
        .acc_hi_nxt(step_hi),
        .acc_lo_nxt(step_lo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        rd_d     = rd_q;
        dz_d     = dz_q;
`ifdef MULDIV_EARLY_EXIT_EN
        ee_d     = ee_q;
        rem_bits = '0;
        sh_amt   = '0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start && !flush) begin
                    op_d     = op_in;
                    rd_d     = rd_in;
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    opnd_d   = is_div_op(op_in) ? src_b : src_a;
                    acc_lo_d = is_div_op(op_in) ? src_a : src_b;
                    dz_d     = is_div_op(op_in) && (src_b == '0);
`ifdef MULDIV_EARLY_EXIT_EN
                    ee_d     = 1'b0;
`endif
                    state_d  = ST_BUSY;
                    // Divide by zero: preload the defined answer and let LAST hold it.
                    if (is_div_op(op_in) && (src_b == '0)) begin
                        acc_hi_d = src_a;
                        acc_lo_d = '1;
                        state_d  = ST_LAST;
                    end
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 2)) state_d = ST_LAST;
`ifdef MULDIV_EARLY_EXIT_EN
                    // Low bits of acc_lo still hold unconsumed multiplier bits.
                    rem_bits = step_lo << (cnt_q + 1'b1);
                    if (!is_div_op(op_q) && (rem_bits == '0)) begin
                        state_d = ST_LAST;
                        ee_d    = 1'b1;
                    end
`endif
                end
            end
            ST_LAST: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
`ifdef MULDIV_EARLY_EXIT_EN
                    if (ee_q) begin
                        sh_amt = CNT_W'(XLEN) - cnt_q;
                        {acc_hi_d, acc_lo_d} = {acc_hi_q, acc_lo_q} >> sh_amt;
                    end else if (!dz_q) begin
                        acc_hi_d = step_hi;
                        acc_lo_d = step_lo;
                    end
`else
                    if (!dz_q) begin
                        acc_hi_d = step_hi;
                        acc_lo_d = step_lo;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            rd_q     <= '0;
            dz_q     <= 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
            ee_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            rd_q     <= rd_d;
            dz_q     <= dz_d;
`ifdef MULDIV_EARLY_EXIT_EN
            ee_q     <= ee_d;
`endif
        end
    end

    // A flushed DONE cycle looks like IDLE so status and valid never disagree.
    assign done_vis     = (state_q == ST_DONE) && !flush;
    assign alu_status   = ((state_q == ST_DONE) && flush) ? ST_IDLE : state_q;
    assign result_valid = done_vis;
    assign result       = done_vis ? (takes_hi(op_q) ? acc_hi_q : acc_lo_q) : '0;
    assign rd_out       = done_vis ? rd_q : '0;

    a_start_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(start && ((state_q == ST_BUSY) || (state_q == ST_LAST))));

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed cases from the test plan plus random ops
// checked against an arithmetic reference model.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] src_a = '0;
    logic [15:0] src_b = '0;
    logic [3:0]  rd_in = '0;
    logic [1:0]  alu_status;
    logic [15:0] result;
    logic [3:0]  rd_out;
    logic        result_valid;

    int n_pass = 0;
    int n_chk  = 0;

    logic [1:0]  cur_op;
    logic [15:0] cur_a, cur_b;
    logic [3:0]  cur_rd;

    always #5 clk = ~clk;

    muldiv_iter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .rd_in       (rd_in),
        .flush       (flush),
        .alu_status  (alu_status),
        .result      (result),
        .rd_out      (rd_out),
        .result_valid(result_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = {16'b0, a} * {16'b0, b};
        case (o)
            2'b00:   return p[15:0];
            2'b01:   return p[31:16];
            2'b10:   return (b == 0) ? 16'hFFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from the launch edge to the DONE cycle.
    function automatic int exp_lat(input logic [1:0] o, input logic [15:0] b);
        int n;
        if (o[1] && b == 0) return 2;
        n = 1;
`ifdef MULDIV_EARLY_EXIT_EN
        if (!o[1]) begin
            for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
            if (n > 15) n = 15;
            return n + 2;
        end
`endif
        return 17 + n - 1;
    endfunction

    // Called at a negedge; returns just after the launch edge with start dropped.
    task automatic launch(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input logic [3:0] r);
        start = 1'b1; op = o; src_a = a; src_b = b; rd_in = r;
        cur_op = o; cur_a = a; cur_b = b; cur_rd = r;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Checks cycles 1..upto after launch (0 = through DONE); ends at that cycle's negedge.
    task automatic follow(input int upto);
        int lat, last;
        lat  = exp_lat(cur_op, cur_b);
        last = (upto == 0 || upto > lat) ? lat : upto;
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            if (t == lat) begin
                chk("done_status", alu_status, 2'b01);
                chk("done_valid", result_valid, 1'b1);
                chk("result", result, model(cur_op, cur_a, cur_b));
                chk("done_rd", rd_out, cur_rd);
            end else begin
                chk("run_status", alu_status, (t == lat - 1) ? 2'b11 : 2'b10);
                chk("run_valid", result_valid, 1'b0);
                chk("run_rd", rd_out, 4'h0);
            end
        end
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, "_status"}, alu_status, 2'b00);
        chk({tag, "_valid"}, result_valid, 1'b0);
        chk({tag, "_result"}, result, 16'h0);
        chk({tag, "_rd"}, rd_out, 4'h0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_status", alu_status, 2'b00);
        chk("rst_result", result, 16'h0);
        chk("rst_rd", rd_out, 4'h0);
        chk("rst_valid", result_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic
        launch(2'b00, 16'h1234, 16'h0010, 4'h5); follow(0); idle_chk("mul_after");
        launch(2'b01, 16'hFFFF, 16'hFFFF, 4'h9); follow(0); idle_chk("mulh_after");
        launch(2'b10, 16'd100, 16'd7, 4'h3);     follow(0); idle_chk("div_after");
        launch(2'b11, 16'd100, 16'd7, 4'h4);     follow(0); idle_chk("rem_after");
        launch(2'b10, 16'h00AB, 16'h0, 4'h6);    follow(0); idle_chk("dz_div_after");
        launch(2'b11, 16'h00AB, 16'h0, 4'h7);    follow(0); idle_chk("dz_rem_after");
        launch(2'b00, 16'd7, 16'd3, 4'h1);       follow(0); idle_chk("mul73_after");

        // Back-to-back launch from DONE
        launch(2'b00, 16'h1234, 16'h0010, 4'h2); follow(0);
        launch(2'b10, 16'd1000, 16'd9, 4'hA);    follow(0); idle_chk("b2b_after");

        // Flush during BUSY
        launch(2'b10, 16'hBEEF, 16'h0013, 4'hB); follow(8);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        idle_chk("flush_busy");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("flush_no_valid", result_valid, 1'b0);
        end

        // Flush and start together in DONE
        launch(2'b00, 16'd5, 16'd6, 4'hC); follow(0);
        flush = 1'b1; start = 1'b1; op = 2'b00; src_a = 16'd9; src_b = 16'd9; rd_in = 4'hD;
        #1;
        chk("fd_status", alu_status, 2'b00);
        chk("fd_valid", result_valid, 1'b0);
        chk("fd_result", result, 16'h0);
        chk("fd_rd", rd_out, 4'h0);
        @(posedge clk);
        #1 begin flush = 1'b0; start = 1'b0; end
        idle_chk("fd_after1");
        idle_chk("fd_after2");

        // Asynchronous reset in the middle of a multiply
        launch(2'b00, 16'd3, 16'd5, 4'h7); follow(4);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_status", alu_status, 2'b00);
        chk("arst_result", result, 16'h0);
        chk("arst_rd", rd_out, 4'h0);
        chk("arst_valid", result_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) idle_chk("arst_idle");

        // Random ops; odd iterations chain straight from DONE
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  ro;
            logic [15:0] ra, rb;
            int          mode;
            ro   = 2'($urandom_range(0, 3));
            ra   = 16'($urandom);
            mode = $urandom_range(0, 3);
            rb   = (mode == 0) ? 16'h0 : (mode == 1) ? 16'($urandom_range(1, 15)) : 16'($urandom);
            launch(ro, ra, rb, 4'($urandom));
            follow(0);
            if (i % 2 == 0) idle_chk("rnd_idle");
        end
        idle_chk("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
